// File: rtl/conv_layer_mem.sv
// Responder-side memories and start handshake for the convolution engine.
// Optional write counter is built only when CONV_LAYER_MEM_WRCNT_EN is defined.
module conv_layer_mem #(
  parameter int DW        = 20,
  parameter int IMG_DEPTH = 4096,
  parameter int L0_DEPTH  = 4096,
  parameter int L1_DEPTH  = 1024,
  parameter int L2_DEPTH  = 2048
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [11:0]   ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  output logic          ready,
  input  logic          busy,
  input  logic [11:0]   iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [11:0]   caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [11:0]   caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  input  logic [2:0]    dmp_sel,
  input  logic [11:0]   dmp_addr,
  output logic [DW-1:0] dmp_data,
  output logic          done,
  output logic [2:0]    err,
  output logic [12:0]   wr_cnt
);

  localparam int IMG_AW = $clog2(IMG_DEPTH);
  localparam int L0_AW  = $clog2(L0_DEPTH);
  localparam int L1_AW  = $clog2(L1_DEPTH);
  localparam int L2_AW  = $clog2(L2_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [2:0] err_q, err_d;

  logic [DW-1:0] img_mem  [IMG_DEPTH];
  logic [DW-1:0] l0k0_mem [L0_DEPTH];
  logic [DW-1:0] l0k1_mem [L0_DEPTH];
  logic [DW-1:0] l1k0_mem [L1_DEPTH];
  logic [DW-1:0] l1k1_mem [L1_DEPTH];
  logic [DW-1:0] l2_mem   [L2_DEPTH];

  function automatic logic sel_valid(input logic [2:0] sel);
    sel_valid = (sel >= 3'd1) && (sel <= 3'd5);
  endfunction

  // Depth check per bank; sel 000 means the image ROM (dump path only).
  function automatic logic in_range(input logic [2:0] sel, input logic [11:0] addr);
    case (sel)
      3'b000:         in_range = {1'b0, addr} < 13'(IMG_DEPTH);
      3'b001, 3'b010: in_range = {1'b0, addr} < 13'(L0_DEPTH);
      3'b011, 3'b100: in_range = {1'b0, addr} < 13'(L1_DEPTH);
      3'b101:         in_range = {1'b0, addr} < 13'(L2_DEPTH);
      default:        in_range = 1'b0;
    endcase
  endfunction

  // Access qualification
  logic wr_ok, wr_inv, wr_oor;
  logic rd_ok, rd_inv, rd_oor;
  logic img_we, ld_err, ld_oor;
  logic start_acc;

  always_comb begin
    wr_ok  = 1'b0;
    wr_inv = 1'b0;
    wr_oor = 1'b0;
    if (cwr) begin
      if (!sel_valid(csel))               wr_inv = 1'b1;
      else if (!in_range(csel, caddr_wr)) wr_oor = 1'b1;
      else                                wr_ok  = 1'b1;
    end
  end

  always_comb begin
    rd_ok  = 1'b0;
    rd_inv = 1'b0;
    rd_oor = 1'b0;
    if (crd) begin
      if (!sel_valid(csel))               rd_inv = 1'b1;
      else if (!in_range(csel, caddr_rd)) rd_oor = 1'b1;
      else                                rd_ok  = 1'b1;
    end
  end

  always_comb begin
    img_we    = 1'b0;
    ld_err    = 1'b0;
    ld_oor    = 1'b0;
    start_acc = start && (state_q == S_IDLE);
    if (ld_valid) begin
      if (state_q != S_IDLE)            ld_err = 1'b1;
      else if (!in_range(3'b000, ld_addr)) ld_oor = 1'b1;
      else                              img_we = 1'b1;
    end
  end

  // Combinational read ports
  assign idata = img_mem[iaddr[IMG_AW-1:0]];

  always_comb begin
    cdata_rd = '0;
    if (rd_ok) begin
      case (csel)
        3'b001:  cdata_rd = l0k0_mem[caddr_rd[L0_AW-1:0]];
        3'b010:  cdata_rd = l0k1_mem[caddr_rd[L0_AW-1:0]];
        3'b011:  cdata_rd = l1k0_mem[caddr_rd[L1_AW-1:0]];
        3'b100:  cdata_rd = l1k1_mem[caddr_rd[L1_AW-1:0]];
        3'b101:  cdata_rd = l2_mem[caddr_rd[L2_AW-1:0]];
        default: cdata_rd = '0;
      endcase
    end
  end

  always_comb begin
    dmp_data = '0;
    if (in_range(dmp_sel, dmp_addr)) begin
      case (dmp_sel)
        3'b000:  dmp_data = img_mem[dmp_addr[IMG_AW-1:0]];
        3'b001:  dmp_data = l0k0_mem[dmp_addr[L0_AW-1:0]];
        3'b010:  dmp_data = l0k1_mem[dmp_addr[L0_AW-1:0]];
        3'b011:  dmp_data = l1k0_mem[dmp_addr[L1_AW-1:0]];
        3'b100:  dmp_data = l1k1_mem[dmp_addr[L1_AW-1:0]];
        3'b101:  dmp_data = l2_mem[dmp_addr[L2_AW-1:0]];
        default: dmp_data = '0;
      endcase
    end
  end

  // Memory contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (img_we) img_mem[ld_addr[IMG_AW-1:0]] <= ld_data;
    if (wr_ok) begin
      case (csel)
        3'b001:  l0k0_mem[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        3'b010:  l0k1_mem[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        3'b011:  l1k0_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        3'b100:  l1k1_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        3'b101:  l2_mem[caddr_wr[L2_AW-1:0]]   <= cdata_wr;
        default: ;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_REQ;
      S_REQ:   if (busy)  state_d = S_RUN;
      S_RUN:   if (!busy) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from state so reset drops them immediately
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_REQ:   ready = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ;
    endcase
  end

  // Sticky error flags
  always_comb begin
    err_d = err_q | {ld_err, wr_inv | rd_inv, wr_oor | rd_oor | ld_oor};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= '0;
    else       err_q <= err_d;
  end

  assign err = err_q;

`ifdef CONV_LAYER_MEM_WRCNT_EN
  logic [12:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (start_acc)                   wr_cnt_d = '0;
    else if (wr_ok && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 13'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_cnt_q <= '0;
    else       wr_cnt_q <= wr_cnt_d;
  end

  assign wr_cnt = wr_cnt_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign wr_cnt           = '0;
`endif

endmodule

// File: tb/tb_conv_layer_mem.sv
// Directed self-checking bench for conv_layer_mem: bank table plus handshake,
// error, collision and reset sequences.
module tb_conv_layer_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic [11:0] ld_addr;
  logic [19:0] ld_data;
  logic        start;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic [19:0] idata;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic [2:0]  csel;
  logic [2:0]  dmp_sel;
  logic [11:0] dmp_addr;
  logic [19:0] dmp_data;
  logic        done;
  logic [2:0]  err;
  logic [12:0] wr_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

`ifdef CONV_LAYER_MEM_WRCNT_EN
  localparam logic [12:0] EXP_CNT3 = 13'd3;
`else
  localparam logic [12:0] EXP_CNT3 = 13'd0;
`endif

  conv_layer_mem #(.DW(20), .IMG_DEPTH(4096), .L0_DEPTH(4096),
                   .L1_DEPTH(1024), .L2_DEPTH(2048)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start), .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .csel(csel), .dmp_sel(dmp_sel), .dmp_addr(dmp_addr), .dmp_data(dmp_data),
    .done(done), .err(err), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [11:0] addr;
    logic [19:0] data;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int done_seen;

  initial begin
    vecs[0] = '{3'b001, 12'd5,    20'h00111};
    vecs[1] = '{3'b010, 12'd5,    20'h00222};
    vecs[2] = '{3'b001, 12'd4095, 20'h8A5A5};
    vecs[3] = '{3'b010, 12'd0,    20'h00ABC};
    vecs[4] = '{3'b011, 12'd0,    20'h33333};
    vecs[5] = '{3'b011, 12'd1023, 20'h3FFFF};
    vecs[6] = '{3'b100, 12'd1023, 20'h44444};
    vecs[7] = '{3'b100, 12'd1,    20'h40001};
    vecs[8] = '{3'b101, 12'd2047, 20'h55555};
    vecs[9] = '{3'b101, 12'd0,    20'h50000};

    reset = 1'b1; ld_valid = 0; ld_addr = '0; ld_data = '0; start = 0; busy = 0;
    iaddr = '0; cwr = 0; caddr_wr = '0; cdata_wr = '0; crd = 0; caddr_rd = '0;
    csel = '0; dmp_sel = '0; dmp_addr = '0;
    step(); step();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    reset = 1'b0;
    step();

    // Image preload in IDLE
    ld_valid = 1; ld_addr = 12'd0;    ld_data = 20'h12345; step();
    ld_addr = 12'hFFF; ld_data = 20'hABCDE; step();
    ld_valid = 0;
    iaddr = 12'hFFF; #1 chk("idata_fff", 32'(idata), 32'hABCDE);
    iaddr = 12'h000; #1 chk("idata_000", 32'(idata), 32'h12345);
    dmp_sel = 3'b000; dmp_addr = 12'hFFF; #1 chk("dmp_img_fff", 32'(dmp_data), 32'hABCDE);

    // Bank table: write all, then read back through both paths
    for (int i = 0; i < 10; i++) begin
      cwr = 1; csel = vecs[i].sel; caddr_wr = vecs[i].addr; cdata_wr = vecs[i].data;
      step();
    end
    cwr = 0;
    for (int i = 0; i < 10; i++) begin
      crd = 1; csel = vecs[i].sel; caddr_rd = vecs[i].addr;
      dmp_sel = vecs[i].sel; dmp_addr = vecs[i].addr;
      #1;
      chk($sformatf("crd_%0d", i), 32'(cdata_rd), 32'(vecs[i].data));
      chk($sformatf("dmp_%0d", i), 32'(dmp_data), 32'(vecs[i].data));
    end
    crd = 0; #1;
    chk("crd_low_zero", 32'(cdata_rd), 32'd0);
    chk("err_clean", 32'(err), 32'd0);

    // Read/write collision on L2[7]
    cwr = 1; csel = 3'b101; caddr_wr = 12'd7; cdata_wr = 20'h00005; step();
    crd = 1; caddr_rd = 12'd7; cdata_wr = 20'h00009; #1;
    chk("coll_old", 32'(cdata_rd), 32'h00005);
    step();
    cwr = 0; #1;
    chk("coll_new", 32'(cdata_rd), 32'h00009);
    crd = 0;

    // Out-of-range write to L1k0 (would alias index 0)
    cwr = 1; csel = 3'b011; caddr_wr = 12'd1024; cdata_wr = 20'hDEAD0; step();
    cwr = 0; #1;
    chk("err_oor", 32'(err), 32'b001);
    dmp_sel = 3'b011; dmp_addr = 12'd0; #1;
    chk("oor_no_write", 32'(dmp_data), 32'h33333);

    // Invalid csel read
    crd = 1; csel = 3'b111; caddr_rd = 12'd5; #1;
    chk("inv_rd_zero", 32'(cdata_rd), 32'd0);
    step();
    crd = 0; #1;
    chk("err_inv", 32'(err), 32'b011);

    // Handshake with three writes while waiting in REQ
    start = 1; step(); start = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        cwr = 1; csel = 3'b101; caddr_wr = 12'(100 + i); cdata_wr = 20'(i + 1);
      end else begin
        cwr = 0;
      end
      #1 chk($sformatf("req_ready_%0d", i), 32'(ready), 32'd1);
      step();
    end
    chk("wr_cnt_3", 32'(wr_cnt), 32'(EXP_CNT3));
    busy = 1; #1;
    chk("ready_before_busy_edge", 32'(ready), 32'd1);
    step();
    chk("ready_in_run", 32'(ready), 32'd0);

    // start ignored in RUN; image load rejected
    start = 1; ld_valid = 1; ld_addr = 12'd0; ld_data = 20'hFFFFF; step();
    start = 0; ld_valid = 0; #1;
    chk("err_ld", 32'(err), 32'b111);
    chk("img_kept", 32'(idata), 32'h12345);
    chk("wr_cnt_kept", 32'(wr_cnt), 32'(EXP_CNT3));
    chk("run_no_done", 32'(done), 32'd0);

    busy = 0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) done_seen++;
      if (i == 0) chk("done_pulse", 32'(done), 32'd1);
    end
    chk("done_count", 32'(done_seen), 32'd1);
    chk("idle_ready", 32'(ready), 32'd0);
    dmp_sel = 3'b101; dmp_addr = 12'd102; #1;
    chk("req_write_l2", 32'(dmp_data), 32'h00003);

    // Reset asserted in REQ: ready drops without a clock edge
    start = 1; step(); start = 0;
    chk("req2_ready", 32'(ready), 32'd1);
    #2 reset = 1; #1;
    chk("async_ready", 32'(ready), 32'd0);
    chk("async_err", 32'(err), 32'd0);
    chk("async_wr_cnt", 32'(wr_cnt), 32'd0);
    step(); reset = 0; step();

    // Reset asserted in RUN
    start = 1; step(); start = 0; busy = 1; step();
    chk("run2_ready", 32'(ready), 32'd0);
    #2 reset = 1; #1;
    chk("run_rst_ready", 32'(ready), 32'd0);
    chk("run_rst_done", 32'(done), 32'd0);
    busy = 0; step(); reset = 0; step();
    chk("post_rst_idle_done", 32'(done), 32'd0);
    dmp_sel = 3'b001; dmp_addr = 12'd5; #1;
    chk("mem_retained", 32'(dmp_data), 32'h00111);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
